// File: rtl/core_run_monitor_if.sv
// Trace readout port of core_run_monitor: one captured instruction record per beat.
// A record transfers on a cycle where tr_valid & tr_ready are both high; while tr_valid is high and tr_ready low, tr_valid and every tr_* field hold.
interface core_run_monitor_if #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
);
    logic             tr_valid;
    logic             tr_ready;
    logic [XLEN-1:0]  tr_pc;
    logic [XLEN-1:0]  tr_inst;
    logic [REG_W-1:0] tr_rs1;
    logic [REG_W-1:0] tr_rs2;
    logic [REG_W-1:0] tr_rd;

    modport master (
        output tr_valid, tr_pc, tr_inst, tr_rs1, tr_rs2, tr_rd,
        input  tr_ready
    );

    modport slave (
        input  tr_valid, tr_pc, tr_inst, tr_rs1, tr_rs2, tr_rd,
        output tr_ready
    );
endinterface

// File: rtl/core_run_monitor.sv
// Run controller for ChronosCore: gates core_en, bounds the run by TIMEOUT cycles or EBREAK,
// and keeps the last DEPTH instruction records in a ring buffer that is drained after the run.
module core_run_monitor #(
    parameter int XLEN    = 32,
    parameter int REG_W   = 5,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 100,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     inst_valid,
    input  logic [XLEN-1:0]          pc,
    input  logic [XLEN-1:0]          inst,
    input  logic [REG_W-1:0]         rs1,
    input  logic [REG_W-1:0]         rs2,
    input  logic [REG_W-1:0]         rd,
    output logic                     core_en,
    output logic                     done,
    output logic                     timed_out,
    output logic                     overflow,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [$clog2(DEPTH):0]   level,
    output logic [1:0]               dbg_state,
    core_run_monitor_if.master       tr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = 2 * XLEN + 3 * REG_W;
    localparam logic [XLEN-1:0] EBREAK = XLEN'(32'h00100073);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_timed_out;
    logic                 r_overflow;
    logic [REC_W-1:0]     r_mem [DEPTH];

    logic                 w_clear;
    logic                 w_wr;
    logic                 w_pop;
    logic                 w_ebreak;
    logic                 w_timeout;
    logic                 w_full;
    logic                 w_tr_valid;
    logic [REC_W-1:0]     w_head;

    assign w_full     = (r_level == LVL_W'(DEPTH));
    assign w_tr_valid = (r_state == DONE) && (r_level != '0);
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_wr        = 1'b0;
        w_pop       = 1'b0;
        w_ebreak    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_clear     = 1'b1;
                end
            end
            RUN: begin
                w_wr      = inst_valid;
                w_ebreak  = inst_valid && (inst == EBREAK);
                // Leaving after this cycle makes cycle_count land exactly on TIMEOUT.
                w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
                if (w_ebreak || w_timeout) w_state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_clear     = 1'b1;
                end else begin
                    w_pop = w_tr_valid && tr.tr_ready;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (r_state == RUN) r_cnt <= r_cnt + 1'b1;
            if (w_timeout && !w_ebreak) r_timed_out <= 1'b1;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                // A full buffer drops its oldest record so the newest DEPTH are kept.
                if (w_full) begin
                    r_rd_ptr   <= r_rd_ptr + 1'b1;
                    r_overflow <= 1'b1;
                end else begin
                    r_level <= r_level + 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_level  <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {pc, inst, rs1, rs2, rd};
    end

    always_comb begin
        tr.tr_valid = w_tr_valid;
        tr.tr_pc    = '0;
        tr.tr_inst  = '0;
        tr.tr_rs1   = '0;
        tr.tr_rs2   = '0;
        tr.tr_rd    = '0;
        if (w_tr_valid) begin
            tr.tr_pc   = w_head[REC_W-1 -: XLEN];
            tr.tr_inst = w_head[REC_W-XLEN-1 -: XLEN];
            tr.tr_rs1  = w_head[3*REG_W-1 -: REG_W];
            tr.tr_rs2  = w_head[2*REG_W-1 -: REG_W];
            tr.tr_rd   = w_head[REG_W-1:0];
        end
    end

    assign core_en     = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign timed_out   = r_timed_out;
    assign overflow    = r_overflow;
    assign cycle_count = r_cnt;
    assign level       = r_level;
    assign dbg_state   = r_state;
endmodule

// File: tb/tb_core_run_monitor.sv
// Directed bench for core_run_monitor: EBREAK stop, timeout, tie-break, readout backpressure,
// restart from DONE and asynchronous reset in the middle of a run.
module tb_core_run_monitor;
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] ALU    = 32'h002081b3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] inst = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [4:0]  rd = '0;
    logic        core_en;
    logic        done;
    logic        timed_out;
    logic        overflow;
    logic [15:0] cycle_count;
    logic [4:0]  level;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    core_run_monitor_if #(.XLEN(32), .REG_W(5)) tr_if ();

    core_run_monitor #(
        .XLEN(32), .REG_W(5), .DEPTH(16), .TIMEOUT(100), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .inst_valid(inst_valid),
        .pc(pc), .inst(inst), .rs1(rs1), .rs2(rs2), .rd(rd),
        .core_en(core_en), .done(done), .timed_out(timed_out), .overflow(overflow),
        .cycle_count(cycle_count), .level(level), .dbg_state(dbg_state),
        .tr(tr_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] p, input logic [31:0] in);
        inst_valid = v;
        pc         = p;
        inst       = in;
        rs1        = p[6:2];
        rs2        = p[6:2] + 5'd1;
        rd         = p[6:2] + 5'd2;
    endtask

    task automatic test_reset();
        tr_if.tr_ready = 1'b0;
        present(1'b0, 32'd0, 32'd0);
        step();
        tests++;
        if ({core_en, done, timed_out, overflow, tr_if.tr_valid} !== 5'b0 ||
            cycle_count !== 16'd0 || level !== 5'd0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_outputs: got en=%b done=%b to=%b ov=%b tv=%b cnt=%0d lvl=%0d st=%0d, required all 0",
                     core_en, done, timed_out, overflow, tr_if.tr_valid, cycle_count, level, dbg_state);
        end
        rst = 1'b1;
        step();
        tests++;
        if (core_en !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_start: core_en=%b required 0", core_en);
        end
    endtask

    task automatic test_ebreak();
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (core_en !== 1'b1 || cycle_count !== 16'd0) begin
            fails++;
            $display("FAIL run_entry: core_en=%b cnt=%0d, required 1 and 0", core_en, cycle_count);
        end
        for (int i = 0; i < 5; i++) begin
            present(1'b1, 32'(4 * i), (i == 4) ? EBREAK : ALU);
            step();
        end
        present(1'b0, 32'd0, 32'd0);
        tests++;
        if (done !== 1'b1 || core_en !== 1'b0 || timed_out !== 1'b0 ||
            level !== 5'd5 || cycle_count !== 16'd5) begin
            fails++;
            $display("FAIL ebreak_stop: done=%b en=%b to=%b lvl=%0d cnt=%0d, required 1 0 0 5 5",
                     done, core_en, timed_out, level, cycle_count);
        end
        tests++;
        if (tr_if.tr_inst !== ALU || tr_if.tr_rs1 !== 5'd0 || tr_if.tr_rs2 !== 5'd1 || tr_if.tr_rd !== 5'd2) begin
            fails++;
            $display("FAIL first_record_fields: inst=%h rs1=%0d rs2=%0d rd=%0d, required %h 0 1 2",
                     tr_if.tr_inst, tr_if.tr_rs1, tr_if.tr_rs2, tr_if.tr_rd, ALU);
        end
        tr_if.tr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (tr_if.tr_valid !== 1'b1 || tr_if.tr_pc !== 32'(4 * k)) begin
                fails++;
                $display("FAIL ebreak_readout: idx=%0d valid=%b pc=%h, required 1 %h",
                         k, tr_if.tr_valid, tr_if.tr_pc, 32'(4 * k));
            end
            step();
        end
        tr_if.tr_ready = 1'b0;
        tests++;
        if (tr_if.tr_valid !== 1'b0 || level !== 5'd0 || tr_if.tr_pc !== 32'd0) begin
            fails++;
            $display("FAIL ebreak_drained: valid=%b lvl=%0d pc=%h, required 0 0 0", tr_if.tr_valid, level, tr_if.tr_pc);
        end
    endtask

    task automatic test_backpressure();
        int pops = 0;
        int cycles = 0;
        logic stalled = 1'b0;
        logic [31:0] held_pc = '0;
        logic [31:0] held_inst = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            present(1'b1, 32'h100 + 32'(4 * i), (i == 4) ? EBREAK : ALU);
            exp_q.push_back(32'h100 + 32'(4 * i));
            step();
        end
        present(1'b0, 32'd0, 32'd0);
        while (pops < 5 && cycles < 200) begin
            tr_if.tr_ready = 1'($urandom_range(0, 1));
            tests++;
            if (tr_if.tr_valid !== 1'b1 || tr_if.tr_pc !== exp_q[0]) begin
                fails++;
                $display("FAIL bp_head: valid=%b pc=%h, required 1 %h", tr_if.tr_valid, tr_if.tr_pc, exp_q[0]);
            end
            if (stalled) begin
                tests++;
                if (tr_if.tr_pc !== held_pc || tr_if.tr_inst !== held_inst) begin
                    fails++;
                    $display("FAIL bp_stable: pc=%h inst=%h, required %h %h", tr_if.tr_pc, tr_if.tr_inst, held_pc, held_inst);
                end
            end
            stalled   = !tr_if.tr_ready;
            held_pc   = tr_if.tr_pc;
            held_inst = tr_if.tr_inst;
            if (tr_if.tr_ready && tr_if.tr_valid) begin
                void'(exp_q.pop_front());
                pops++;
            end
            step();
            cycles++;
        end
        tr_if.tr_ready = 1'b0;
        tests++;
        if (pops != 5 || tr_if.tr_valid !== 1'b0 || level !== 5'd0) begin
            fails++;
            $display("FAIL bp_end: pops=%0d valid=%b lvl=%0d, required 5 0 0", pops, tr_if.tr_valid, level);
        end
    endtask

    task automatic test_timeout();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            present(1'b1, 32'(4 * i), ALU);
            if (i == 99) begin
                tests++;
                if (done !== 1'b0 || core_en !== 1'b1 || cycle_count !== 16'd99) begin
                    fails++;
                    $display("FAIL timeout_early: done=%b en=%b cnt=%0d, required 0 1 99", done, core_en, cycle_count);
                end
            end
            step();
        end
        present(1'b0, 32'd0, 32'd0);
        tests++;
        if (done !== 1'b1 || cycle_count !== 16'd100 || timed_out !== 1'b1 ||
            overflow !== 1'b1 || level !== 5'd16) begin
            fails++;
            $display("FAIL timeout_stop: done=%b cnt=%0d to=%b ov=%b lvl=%0d, required 1 100 1 1 16",
                     done, cycle_count, timed_out, overflow, level);
        end
        tests++;
        if (tr_if.tr_pc !== 32'd336) begin
            fails++;
            $display("FAIL timeout_oldest: pc=%h, required %h", tr_if.tr_pc, 32'd336);
        end
    endtask

    task automatic test_restart();
        tr_if.tr_ready = 1'b1;
        for (int k = 0; k < 13; k++) step();
        tests++;
        if (level !== 5'd3) begin
            fails++;
            $display("FAIL restart_pre_level: lvl=%0d, required 3", level);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        tr_if.tr_ready = 1'b0;
        tests++;
        if (core_en !== 1'b1 || done !== 1'b0 || level !== 5'd0 || overflow !== 1'b0 ||
            timed_out !== 1'b0 || cycle_count !== 16'd0) begin
            fails++;
            $display("FAIL restart_clear: en=%b done=%b lvl=%0d ov=%b to=%b cnt=%0d, required 1 0 0 0 0 0",
                     core_en, done, level, overflow, timed_out, cycle_count);
        end
        present(1'b1, 32'h40, EBREAK);
        step();
        present(1'b0, 32'd0, 32'd0);
        tests++;
        if (done !== 1'b1 || level !== 5'd1 || tr_if.tr_pc !== 32'h40 || cycle_count !== 16'd1) begin
            fails++;
            $display("FAIL restart_run: done=%b lvl=%0d pc=%h cnt=%0d, required 1 1 40 1",
                     done, level, tr_if.tr_pc, cycle_count);
        end
    endtask

    task automatic test_simultaneous();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            present(1'b1, 32'(4 * i), (i == 99) ? EBREAK : ALU);
            step();
        end
        present(1'b0, 32'd0, 32'd0);
        tests++;
        if (done !== 1'b1 || timed_out !== 1'b0 || cycle_count !== 16'd100 || level !== 5'd16) begin
            fails++;
            $display("FAIL simul_stop: done=%b to=%b cnt=%0d lvl=%0d, required 1 0 100 16",
                     done, timed_out, cycle_count, level);
        end
        tr_if.tr_ready = 1'b1;
        for (int k = 0; k < 15; k++) step();
        tr_if.tr_ready = 1'b0;
        tests++;
        if (tr_if.tr_inst !== EBREAK || tr_if.tr_pc !== 32'd396 || level !== 5'd1) begin
            fails++;
            $display("FAIL simul_last: inst=%h pc=%h lvl=%0d, required %h %h 1",
                     tr_if.tr_inst, tr_if.tr_pc, level, EBREAK, 32'd396);
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            present(1'b1, 32'(4 * i), ALU);
            step();
        end
        tests++;
        if (core_en !== 1'b1 || cycle_count !== 16'd6 || level !== 5'd6) begin
            fails++;
            $display("FAIL midrun_pre: en=%b cnt=%0d lvl=%0d, required 1 6 6", core_en, cycle_count, level);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (core_en !== 1'b0 || done !== 1'b0 || level !== 5'd0 || cycle_count !== 16'd0 ||
            tr_if.tr_valid !== 1'b0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL midrun_async: en=%b done=%b lvl=%0d cnt=%0d tv=%b st=%0d, required all 0",
                     core_en, done, level, cycle_count, tr_if.tr_valid, dbg_state);
        end
        present(1'b0, 32'd0, 32'd0);
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) step();
        tests++;
        if (core_en !== 1'b0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL midrun_needs_start: en=%b st=%0d, required 0 0", core_en, dbg_state);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (core_en !== 1'b1 || cycle_count !== 16'd0) begin
            fails++;
            $display("FAIL midrun_restart: en=%b cnt=%0d, required 1 0", core_en, cycle_count);
        end
    endtask

    initial begin
        tr_if.tr_ready = 1'b0;
        test_reset();
        test_ebreak();
        test_backpressure();
        test_timeout();
        test_restart();
        test_simultaneous();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
